gpio_config_loader: RTL and testbench
=====================================

GPIO_CONFIG_LOADER -- requirements
Module: gpio_config_loader

Interface
REQ-001 SHALL have parameter N_GPIO, default 38: number of GPIO control blocks in the serial chain (legal range 1..64).
REQ-002 SHALL have parameter CLK_DIV, default 2: wb_clk_i cycles per serial_clock phase (legal range 1..255).
REQ-003 SHALL have port wb_clk_i, input, 1: the single clock; all logic rises on it.
REQ-004 SHALL have port wb_rst_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to load the whole chain.
REQ-006 SHALL have port gpio_config, input, N_GPIO*10: 10-bit words; word i occupies bits [10*i+9:10*i].
REQ-007 SHALL have port busy, output, 1: high while a load sequence is in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when a sequence completes.
REQ-009 SHALL have port serial_clock, output, 1: shift clock to the chain.
REQ-010 SHALL have port serial_data, output, 1: shift data to the chain.
REQ-011 SHALL have port serial_load, output, 1: latch strobe to the chain.
REQ-012 SHALL have port serial_resetn, output, 1: active-low chain reset.

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT_LO, SHIFT_HI, LOAD and DONE.
REQ-014 IDLE SHALL hold busy=0, serial_clock=0, serial_load=0 and serial_data=0.
REQ-015 In IDLE, start=1 SHALL do all of the following on the same edge:
- snapshot gpio_config into an internal shadow register;
- clear the bit counter;
- enter SHIFT_LO.
REQ-016 start SHALL be ignored in every state other than IDLE, with no queuing.
REQ-017 Bit order:
- words are shifted highest index first (word N_GPIO-1 first, word 0 last);
- within each word, bits go MSB first;
- total shifted bits = N_GPIO*10.
REQ-018 In SHIFT_LO, serial_clock SHALL be 0 and serial_data SHALL present the current bit; the state SHALL last exactly CLK_DIV cycles, then go to SHIFT_HI.
REQ-019 In SHIFT_HI, serial_clock SHALL be 1 with serial_data held stable; the state SHALL last exactly CLK_DIV cycles.
REQ-020 On leaving SHIFT_HI, the bit counter SHALL increment. The FSM SHALL then go to SHIFT_LO if bits remain, otherwise to LOAD.
REQ-021 In LOAD, serial_load SHALL be 1 and serial_clock 0 for exactly CLK_DIV cycles, then the FSM SHALL go to DONE.
REQ-022 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE. A start in the DONE cycle SHALL be ignored.
REQ-023 busy SHALL be 1 in SHIFT_LO, SHIFT_HI, LOAD and DONE.
REQ-024 Sequence length from the start edge to the done pulse SHALL be N_GPIO*20*CLK_DIV + CLK_DIV + 1 cycles.
REQ-025 Changes to gpio_config during busy SHALL NOT affect the sequence in flight.
REQ-026 The bit counter SHALL be clog2(N_GPIO*10+1) bits wide. The phase counter SHALL be 8 bits wide. Neither counter SHALL wrap within a sequence.
REQ-027 All outputs SHALL be registered, so there are no combinational paths from inputs to outputs.

Reset
REQ-028 While wb_rst_i=1, on each edge:
- FSM = IDLE;
- busy = 0, done = 0;
- serial_clock = 0, serial_data = 0, serial_load = 0;
- serial_resetn = 0;
- counters and the shadow register cleared.
REQ-029 serial_resetn SHALL be 1 from the first edge with wb_rst_i=0.
REQ-030 Reset asserted mid-sequence SHALL abort it on that edge, with no done pulse and no serial_load pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the constant GPIO_CFG_W=10 and the reset-default word GPIO_CFG_DEFAULT=10'h007.
REQ-032 One sub-module, gpio_cfg_phase_timer, SHALL be used. It is the CLK_DIV down-counter that raises phase_end.
REQ-033 Default per-pad words SHALL be supplied externally (from the per-pad defaults blocks); the loader SHALL hold no pad policy.

Verification
REQ-034 N_GPIO=2, CLK_DIV=2, config={10'h3FF,10'h001}, start pulse -> the bench SHALL check:
- serial_data sampled at rising serial_clock = 1111111111 then 0000000001;
- 20 rising edges;
- serial_load high 2 cycles;
- done at cycle 83.
REQ-035 CLK_DIV=1, N_GPIO=1, word 10'h2AA -> serial_data alternates 1010101010; done at cycle 22; busy high cycles 1..22.
REQ-036 start re-pulsed during SHIFT and in the DONE cycle -> exactly one sequence and one done pulse.
REQ-037 gpio_config changed to all-ones mid-sequence -> shifted bits match the snapshot taken at start.
REQ-038 wb_rst_i pulsed at bit 7 -> the bench SHALL check all of the following:
- next edge has all outputs 0 and serial_resetn=0;
- no done or serial_load pulse;
- a new start after reset completes normally.
REQ-039 Back-to-back: start on the cycle after done -> second sequence identical in length and timing (REQ-024).

Source files
------------

// File: rtl/gpio_config_loader_pkg.sv
// Shared types and constants for the GPIO configuration serial loader.
// Holds the loader FSM state encoding and the per-pad word geometry.
package gpio_config_loader_pkg;

    localparam int GPIO_CFG_W = 10;
    localparam logic [GPIO_CFG_W-1:0] GPIO_CFG_DEFAULT = 10'h007;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } gpio_ld_state_e;

endpackage

// File: rtl/gpio_cfg_phase_timer.sv
// CLK_DIV down-counter: load_i restarts a phase, phase_end_o is high on its last cycle.
// One-cycle load latency; no backpressure, the owner decides when to reload.
module gpio_cfg_phase_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic load_i,
    output logic phase_end_o
);

    logic [7:0] cnt_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= 8'(CLK_DIV - 1);
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign phase_end_o = (cnt_q == 8'd0);

endmodule

// File: rtl/gpio_config_loader.sv
// Serialises N_GPIO 10-bit pad words (highest word first, MSB first) onto the GPIO chain, then strobes load.
// All outputs registered; start is accepted only in IDLE, with no queuing and no backpressure.
module gpio_config_loader
    import gpio_config_loader_pkg::*;
#(
    parameter int N_GPIO  = 38,
    parameter int CLK_DIV = 2
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         start,
    input  logic [N_GPIO*GPIO_CFG_W-1:0] gpio_config,
    output logic                         busy,
    output logic                         done,
    output logic                         serial_clock,
    output logic                         serial_data,
    output logic                         serial_load,
    output logic                         serial_resetn
);

    localparam int TOTAL = N_GPIO * GPIO_CFG_W;
    localparam int CNT_W = $clog2(TOTAL + 1);

    gpio_ld_state_e   state_q, state_d;
    logic [TOTAL-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             phase_end;
    logic             timer_load;

    logic busy_q, done_q, sclk_q, sdata_q, sload_q, sresetn_q;

    gpio_cfg_phase_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_phase_timer (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .load_i     (timer_load),
        .phase_end_o(phase_end)
    );

    // The shadow's MSB is always the bit on the wire: the flattened vector
    // already orders word N_GPIO-1 MSB first down to word 0 LSB.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        bit_cnt_d  = bit_cnt_q;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d   = gpio_config;
                    bit_cnt_d  = '0;
                    timer_load = 1'b1;
                    state_d    = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    timer_load = 1'b1;
                    state_d    = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    timer_load = 1'b1;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == CNT_W'(TOTAL)) begin
                        state_d = LOAD;
                    end else begin
                        shadow_d = {shadow_q[TOTAL-2:0], 1'b0};
                        state_d  = SHIFT_LO;
                    end
                end
            end
            LOAD: begin
                if (phase_end) begin
                    timer_load = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Outputs are decoded from the next state so they align with the state they describe.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            sload_q   <= 1'b0;
            sresetn_q <= 1'b0;
        end else begin
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            sclk_q    <= (state_d == SHIFT_HI);
            sdata_q   <= ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shadow_d[TOTAL-1] : 1'b0;
            sload_q   <= (state_d == LOAD);
            sresetn_q <= 1'b1;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign serial_clock  = sclk_q;
    assign serial_data   = sdata_q;
    assign serial_load   = sload_q;
    assign serial_resetn = sresetn_q;

endmodule

// File: tb/tb_gpio_config_loader.sv
// Bench for gpio_config_loader: two instances (N=2/DIV=2 and N=1/DIV=1) against a timeline model.
module tb_gpio_config_loader;
    import gpio_config_loader_pkg::*;

    localparam int NA = 2, CDA = 2, NB = 1, CDB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_in[2];
    logic         start_in[2];
    logic [639:0] cfg_in[2];
    logic busy_w[2], done_w[2], sclk_w[2], sdata_w[2], sload_w[2], srstn_w[2];

    gpio_config_loader #(.N_GPIO(NA), .CLK_DIV(CDA)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst_in[0]), .start(start_in[0]),
        .gpio_config(cfg_in[0][NA*10-1:0]),
        .busy(busy_w[0]), .done(done_w[0]), .serial_clock(sclk_w[0]),
        .serial_data(sdata_w[0]), .serial_load(sload_w[0]), .serial_resetn(srstn_w[0])
    );

    gpio_config_loader #(.N_GPIO(NB), .CLK_DIV(CDB)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst_in[1]), .start(start_in[1]),
        .gpio_config(cfg_in[1][NB*10-1:0]),
        .busy(busy_w[1]), .done(done_w[1]), .serial_clock(sclk_w[1]),
        .serial_data(sdata_w[1]), .serial_load(sload_w[1]), .serial_resetn(srstn_w[1])
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: whether a sequence is running, cycles since its start edge, its snapshot.
    bit           act[2];
    int           tt[2];
    logic [639:0] snap[2];
    int           sc[2];
    logic         rst_last[2];

    logic         prev_sclk[2];
    int           rises[2], loads[2], dones[2], done_cyc[2], busy_cnt[2];
    logic [63:0]  bits[2];

    function automatic int nn(int d);
        return (d == 0) ? NA : NB;
    endfunction

    function automatic int cdd(int d);
        return (d == 0) ? CDA : CDB;
    endfunction

    // t = cycles since the start edge; each bit spans 2*cd cycles, then cd load cycles, then done.
    function automatic logic [4:0] expect_outs(int n, int cd, logic [639:0] s, bit a, int t);
        int nb;
        nb = n * 20 * cd;
        if (!a) return 5'b00000;
        if (t < nb) return {1'b1, 1'b0, ((t % (2 * cd)) >= cd), s[n*10-1-t/(2*cd)], 1'b0};
        if (t < nb + cd) return 5'b10001;
        return 5'b11000;
    endfunction

    task automatic chk(string name, longint actual, longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        logic [4:0] e;
        logic [5:0] av, ev;
        int         len;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            len = nn(d) * 20 * cdd(d) + cdd(d) + 1;
            if (rst_in[d]) begin
                act[d] = 1'b0;
            end else if (act[d]) begin
                tt[d]++;
                if (tt[d] == len) act[d] = 1'b0;
            end else if (start_in[d]) begin
                act[d]  = 1'b1;
                tt[d]   = 0;
                snap[d] = cfg_in[d];
                sc[d]   = cyc;
            end
            rst_last[d] = rst_in[d];
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            e  = expect_outs(nn(d), cdd(d), snap[d], act[d], tt[d]);
            ev = {e, ~rst_last[d]};
            av = {busy_w[d], done_w[d], sclk_w[d], sdata_w[d], sload_w[d], srstn_w[d]};
            total++;
            if (av !== ev) begin
                bad++;
                $display("FAIL cycle_check dut%0d cyc=%0d got=%b expected=%b (busy done sclk sdata load resetn)",
                         d, cyc, av, ev);
            end
            if (sclk_w[d] === 1'b1 && prev_sclk[d] === 1'b0) begin
                rises[d]++;
                bits[d] = {bits[d][62:0], sdata_w[d]};
            end
            prev_sclk[d] = sclk_w[d];
            if (sload_w[d] === 1'b1) loads[d]++;
            if (busy_w[d] === 1'b1) busy_cnt[d]++;
            if (done_w[d] === 1'b1) begin
                dones[d]++;
                done_cyc[d] = cyc - sc[d] + 1;
            end
        end
    endtask

    task automatic pulse_start(int d);
        start_in[d] = 1'b1;
        tick();
        start_in[d] = 1'b0;
    endtask

    task automatic wait_done(int d, int budget);
        int d0;
        d0 = dones[d];
        for (int i = 0; i < budget; i++) begin
            tick();
            if (dones[d] != d0) return;
        end
        chk("done_timeout", 0, 1);
    endtask

    initial begin
        int          r0, l0, n0, b0;
        logic [31:0] rnd;
        logic [19:0] word;

        for (int d = 0; d < 2; d++) begin
            rst_in[d] = 1'b1; start_in[d] = 1'b0; cfg_in[d] = '0;
            act[d] = 1'b0; tt[d] = 0; snap[d] = '0; sc[d] = 0; rst_last[d] = 1'b1;
            prev_sclk[d] = 1'b0; rises[d] = 0; loads[d] = 0; dones[d] = 0;
            done_cyc[d] = 0; busy_cnt[d] = 0; bits[d] = '0;
        end
        repeat (3) tick();
        chk("reset_outs_a", {busy_w[0], done_w[0], sclk_w[0], sdata_w[0], sload_w[0], srstn_w[0]}, 0);
        rst_in[0] = 1'b0; rst_in[1] = 1'b0;
        tick();
        chk("resetn_after_release", srstn_w[0], 1);
        tick();

        // Two-word chain: 3FF then 001
        cfg_in[0] = 640'({10'h3FF, 10'h001});
        r0 = rises[0]; l0 = loads[0];
        pulse_start(0);
        wait_done(0, 300);
        chk("a_bits", bits[0][19:0], 20'b1111111111_0000000001);
        chk("a_rises", rises[0] - r0, 20);
        chk("a_load_cycles", loads[0] - l0, 2);
        chk("a_done_cycle", done_cyc[0], 83);
        repeat (3) tick();

        // Single word, fastest divider
        cfg_in[1] = 640'(10'h2AA);
        b0 = busy_cnt[1];
        pulse_start(1);
        chk("b_busy_cycle1", busy_w[1], 1);
        wait_done(1, 100);
        chk("b_bits", bits[1][9:0], 10'b1010101010);
        chk("b_done_cycle", done_cyc[1], 22);
        tick();
        chk("b_busy_cycles", busy_cnt[1] - b0, 22);

        // Re-starts during SHIFT and in the DONE cycle are ignored
        rnd = $urandom; cfg_in[0] = 640'(rnd[19:0]);
        n0 = dones[0];
        pulse_start(0);
        repeat (10) tick();
        pulse_start(0);
        wait_done(0, 300);
        pulse_start(0);
        repeat (5) tick();
        chk("restart_done_count", dones[0] - n0, 1);
        chk("restart_idle_busy", busy_w[0], 0);

        // Config changed mid-sequence does not leak into the shifted bits
        rnd = $urandom; word = rnd[19:0];
        cfg_in[0] = 640'(word);
        pulse_start(0);
        repeat (15) tick();
        cfg_in[0] = '1;
        wait_done(0, 300);
        chk("snapshot_bits", bits[0][19:0], word);
        repeat (2) tick();

        // Reset at bit 7 aborts with no load or done
        cfg_in[0] = 640'({GPIO_CFG_DEFAULT, 10'h155});
        r0 = rises[0]; l0 = loads[0]; n0 = dones[0];
        pulse_start(0);
        for (int i = 0; i < 200 && (rises[0] - r0) < 7; i++) tick();
        chk("bit7_reached", rises[0] - r0, 7);
        rst_in[0] = 1'b1;
        tick();
        chk("midrst_outs", {busy_w[0], done_w[0], sclk_w[0], sdata_w[0], sload_w[0], srstn_w[0]}, 0);
        rst_in[0] = 1'b0;
        repeat (100) tick();
        chk("midrst_no_load", loads[0] - l0, 0);
        chk("midrst_no_done", dones[0] - n0, 0);
        pulse_start(0);
        wait_done(0, 300);
        chk("post_rst_done_cycle", done_cyc[0], 83);
        chk("post_rst_bits", bits[0][19:0], {GPIO_CFG_DEFAULT, 10'h155});

        // Back-to-back: start on the cycle after done
        tick();
        rnd = $urandom; cfg_in[0] = 640'(rnd[19:0]);
        pulse_start(0);
        wait_done(0, 300);
        chk("b2b_done_cycle", done_cyc[0], 83);
        chk("b2b_bits", bits[0][19:0], rnd[19:0]);

        // Random traffic on both instances; the per-cycle model check does the work
        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < 2; d++) begin
                rnd         = $urandom;
                start_in[d] = ($urandom_range(0, 15) == 0);
                cfg_in[d]   = 640'(rnd[19:0]);
                rst_in[d]   = ($urandom_range(0, 299) == 0);
            end
            tick();
        end
        for (int d = 0; d < 2; d++) begin
            start_in[d] = 1'b0;
            rst_in[d]   = 1'b0;
        end
        repeat (120) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
